// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg - shared types for the fetch/data memory arbiter.
// Build option: MEM_ARB_FAIR_EN compiles in the fetch anti-starvation counter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick - owner selection from pending requests and starve count.
// Build option: MEM_ARB_FAIR_EN lets a starved fetch beat data.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve,
  output logic             any,
  output owner_t           owner
);

  logic fetch_turn;

`ifdef MEM_ARB_FAIR_EN
  assign fetch_turn = i_req && (starve == CNT_W'(STARVE_MAX));
`else
  localparam int unused_max = STARVE_MAX;
  logic unused_starve;
  assign unused_starve = ^starve;
  assign fetch_turn    = 1'b0;
`endif

  assign any = i_req | d_req;

  // data first, unless fetch has waited through its quota
  always_comb begin
    owner = OWN_I;
    if (d_req && !fetch_turn) owner = OWN_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter - shares one single-port memory between fetch and data.
// Build option: MEM_ARB_FAIR_EN enables the fetch anti-starvation counter.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  state_t           state;
  owner_t           owner;
  owner_t           pick;
  logic             any;
  logic [CNT_W-1:0] starve;
  logic             accept;
  logic             done;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .starve(starve),
    .any   (any),
    .owner (pick)
  );

  assign accept = (state == ISSUE) && m_ready;
  assign done   = (state == WAIT) && m_rvalid;

  assign i_gnt    = accept && (owner == OWN_I);
  assign d_gnt    = accept && (owner == OWN_D);
  assign i_rvalid = done && (owner == OWN_I);
  assign d_rvalid = done && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;
  assign busy     = (state != IDLE);

  // transaction FSM; memory-side request fields are registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= OWN_I;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state <= ISSUE;
            owner <= pick;
            m_req <= 1'b1;
            if (pick == OWN_D) begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (m_ready) begin
            state <= WAIT;
            m_req <= 1'b0;
          end
        end
        WAIT: begin
          if (m_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_FAIR_EN
  // counts data grants taken while fetch is left waiting
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve <= '0;
    end else if (!i_req || i_gnt) begin
      starve <= '0;
    end else if (d_gnt && (starve != CNT_W'(STARVE_MAX))) begin
      starve <= starve + CNT_W'(1);
    end
  end
`else
  assign starve = '0;
`endif

endmodule
